// File: rtl/isl58x_pkg.sv
// ISL58315 sequencer shared definitions.
// Holds the controller state encoding, pixel width and RGB555 field layout.
package isl58x_pkg;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_WAKE = 2'd1,
      ST_RUN  = 2'd2,
      ST_STOP = 2'd3
   } state_t;

   localparam int PIX_W = 15;
   localparam int CH_W  = 5;
   localparam int R_LSB = 10;
   localparam int G_LSB = 5;
   localparam int B_LSB = 0;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/isl58x_raster_cnt.sv
// Raster position counter: advances one slot per pixel tick and wraps.
// Ports: clk_i, sync_rst_i, i_clr (hold at slot 0,0), i_tick,
//        o_h_cnt, o_v_cnt, o_active, o_last_slot, o_frame_first.
module isl58x_raster_cnt
   import isl58x_pkg::*;
#(
   parameter int H_ACTIVE = 1280,
   parameter int H_BLANK  = 160,
   parameter int V_ACTIVE = 800,
   parameter int V_BLANK  = 20,
   parameter int HW = $clog2(H_ACTIVE + H_BLANK),
   parameter int VW = $clog2(V_ACTIVE + V_BLANK)
)(
   input  logic          clk_i,
   input  logic          sync_rst_i,
   input  logic          i_clr,
   input  logic          i_tick,
   output logic [HW-1:0] o_h_cnt,
   output logic [VW-1:0] o_v_cnt,
   output logic          o_active,
   output logic          o_last_slot,
   output logic          o_frame_first
);

   localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE + H_BLANK - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE + V_BLANK - 1);
   // One extra bit so an all-active line still compares correctly.
   localparam logic [HW:0]   H_ACT  = (HW+1)'(H_ACTIVE);
   localparam logic [VW:0]   V_ACT  = (VW+1)'(V_ACTIVE);

   logic [HW-1:0] r_h;
   logic [VW-1:0] r_v;

   always_ff @(posedge clk_i) begin
      if (sync_rst_i || i_clr) begin
         r_h <= '0;
         r_v <= '0;
      end else if (i_tick) begin
         if (r_h == H_LAST) begin
            r_h <= '0;
            r_v <= (r_v == V_LAST) ? '0 : r_v + 1'b1;
         end else begin
            r_h <= r_h + 1'b1;
         end
      end
   end

   assign o_h_cnt       = r_h;
   assign o_v_cnt       = r_v;
   assign o_active      = ({1'b0, r_h} < H_ACT) && ({1'b0, r_v} < V_ACT);
   assign o_last_slot   = (r_h == H_LAST) && (r_v == V_LAST);
   assign o_frame_first = (r_h == '0) && (r_v == '0);

endmodule

// File: rtl/isl58x_seq_ctrl.sv
// ISL58315 power sequencer, pixel clock divider and raster timing controller.
// Ports: clk_i, sync_rst_i, enable_i, rtz_mode_i; pixel stream pix_i/pix_vld_i/
//   pix_rdy_o; DAC pins isl58x_D/CLK/RTZ/LOWP/CE; frame_start_o, running_o,
//   underflow_cnt_o (saturating count of starved active slots).
module isl58x_seq_ctrl
   import isl58x_pkg::*;
#(
   parameter int CLK_DIV   = 4,
   parameter int H_ACTIVE  = 1280,
   parameter int H_BLANK   = 160,
   parameter int V_ACTIVE  = 800,
   parameter int V_BLANK   = 20,
   parameter int PWRUP_CYC = 1000
)(
   input  logic             clk_i,
   input  logic             sync_rst_i,
   input  logic             enable_i,
   input  logic             rtz_mode_i,
   input  logic [PIX_W-1:0] pix_i,
   input  logic             pix_vld_i,
   output logic             pix_rdy_o,
   output logic [PIX_W-1:0] isl58x_D,
   output logic             isl58x_CLK,
   output logic             isl58x_RTZ,
   output logic             isl58x_LOWP,
   output logic             isl58x_CE,
   output logic             frame_start_o,
   output logic             running_o,
   output logic [15:0]      underflow_cnt_o
);

   localparam int HW     = $clog2(H_ACTIVE + H_BLANK);
   localparam int VW     = $clog2(V_ACTIVE + V_BLANK);
   localparam int PH_W   = $clog2(CLK_DIV);
   localparam int WT_MAX = (PWRUP_CYC > CLK_DIV) ? PWRUP_CYC : CLK_DIV;
   localparam int WT_W   = $clog2(WT_MAX + 1);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
   localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV / 2);
   localparam logic [WT_W-1:0] WT_PWR  = WT_W'(PWRUP_CYC - 1);
   localparam logic [WT_W-1:0] WT_STOP = WT_W'(CLK_DIV - 1);

   state_t r_state;
   state_t w_nxt;

   logic [WT_W-1:0]  r_wait;
   logic [PH_W-1:0]  r_phase;
   logic             r_eof;
   logic [PIX_W-1:0] r_d;
   logic             r_clk;
   logic             r_rtz;
   logic             r_lowp;
   logic             r_ce;
   logic             r_fs;
   logic             r_running;
   logic [15:0]      r_underflow;

   logic          w_run;
   logic          w_tick;
   logic          w_slot_end;
   logic [HW-1:0] w_h_cnt;
   logic [VW-1:0] w_v_cnt;
   logic          w_active;
   logic          w_last_slot;
   logic          w_frame_first;
   logic          w_unused_pos;

   assign w_run      = (r_state == ST_RUN);
   assign w_tick     = w_run && (r_phase == '0);
   assign w_slot_end = w_run && (r_phase == PH_LAST);

   isl58x_raster_cnt #(
      .H_ACTIVE (H_ACTIVE),
      .H_BLANK  (H_BLANK),
      .V_ACTIVE (V_ACTIVE),
      .V_BLANK  (V_BLANK),
      .HW       (HW),
      .VW       (VW)
   ) u_raster (
      .clk_i         (clk_i),
      .sync_rst_i    (sync_rst_i),
      .i_clr         (!w_run),
      .i_tick        (w_tick),
      .o_h_cnt       (w_h_cnt),
      .o_v_cnt       (w_v_cnt),
      .o_active      (w_active),
      .o_last_slot   (w_last_slot),
      .o_frame_first (w_frame_first)
   );

   assign w_unused_pos = ^{w_h_cnt, w_v_cnt};

   always_ff @(posedge clk_i) begin
      if (sync_rst_i) r_state <= ST_OFF;
      else            r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         ST_OFF:  if (enable_i) w_nxt = ST_WAKE;
         ST_WAKE: begin
            if (!enable_i)             w_nxt = ST_OFF;
            else if (r_wait == WT_PWR) w_nxt = ST_RUN;
         end
         // Stop only once the final slot of the frame has fully elapsed.
         ST_RUN:  if (w_slot_end && r_eof && !enable_i) w_nxt = ST_STOP;
         ST_STOP: if (r_wait == WT_STOP) w_nxt = ST_OFF;
         default: w_nxt = ST_OFF;
      endcase
   end

   // Shared dwell counter for WAKE and STOP; restarts on every state change.
   always_ff @(posedge clk_i) begin
      if (sync_rst_i || (r_state != w_nxt)) r_wait <= '0;
      else if (r_state == ST_WAKE || r_state == ST_STOP) r_wait <= r_wait + 1'b1;
      else r_wait <= '0;
   end

   always_ff @(posedge clk_i) begin
      if (sync_rst_i || !w_run)   r_phase <= '0;
      else if (r_phase == PH_LAST) r_phase <= '0;
      else                         r_phase <= r_phase + 1'b1;
   end

   // Remembers that the slot now in progress is the frame's last one.
   always_ff @(posedge clk_i) begin
      if (sync_rst_i || !w_run) r_eof <= 1'b0;
      else if (w_tick)          r_eof <= w_last_slot;
   end

   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         r_d         <= '0;
         r_clk       <= 1'b0;
         r_rtz       <= 1'b0;
         r_lowp      <= 1'b1;
         r_ce        <= 1'b0;
         r_fs        <= 1'b0;
         r_running   <= 1'b0;
         r_underflow <= '0;
      end else begin
         r_lowp    <= (w_nxt == ST_OFF);
         r_ce      <= (w_nxt == ST_RUN);
         r_running <= (w_nxt == ST_RUN);
         // Registered from the phase, so CLK rises CLK_DIV/2 after D moves.
         r_clk <= w_run && (w_nxt == ST_RUN) && (r_phase >= PH_HALF);
         // Raised for the next cycle when it is the tick of slot (0,0).
         r_fs  <= (w_nxt == ST_RUN) && (!w_run || r_phase == PH_LAST)
                  && w_frame_first;
         if (r_state == ST_OFF && w_nxt == ST_WAKE) r_rtz <= rtz_mode_i;
         if (w_nxt != ST_RUN) r_d <= '0;
         else if (w_tick)     r_d <= (w_active && pix_vld_i) ? pix_i : '0;
         if (w_tick && w_active && !pix_vld_i)
            r_underflow <= sat_inc16(r_underflow);
      end
   end

   assign pix_rdy_o       = w_tick && w_active;
   assign isl58x_D        = r_d;
   assign isl58x_CLK      = r_clk;
   assign isl58x_RTZ      = r_rtz;
   assign isl58x_LOWP     = r_lowp;
   assign isl58x_CE       = r_ce;
   assign frame_start_o   = r_fs;
   assign running_o       = r_running;
   assign underflow_cnt_o = r_underflow;

endmodule

// File: tb/tb_isl58x_seq_ctrl.sv
// Self-checking bench for isl58x_seq_ctrl on a 6x3-slot raster.
// Expected values come from slot arithmetic on the cycle count since RUN entry.
module tb_isl58x_seq_ctrl;

   localparam int DIV = 4;
   localparam int HA  = 4;
   localparam int HB  = 2;
   localparam int VA  = 2;
   localparam int VB  = 1;
   localparam int PWR = 1000;
   localparam int HT  = HA + HB;
   localparam int FT  = HT * (VA + VB);
   localparam int FC  = FT * DIV;

   logic        clk = 1'b0;
   logic        sync_rst_i = 1'b1;
   logic        enable_i = 1'b0;
   logic        rtz_mode_i = 1'b0;
   logic [14:0] pix_i = '0;
   logic        pix_vld_i = 1'b0;
   logic        pix_rdy_o;
   logic [14:0] isl58x_D;
   logic        isl58x_CLK;
   logic        isl58x_RTZ;
   logic        isl58x_LOWP;
   logic        isl58x_CE;
   logic        frame_start_o;
   logic        running_o;
   logic [15:0] underflow_cnt_o;

   int          n_vec = 0;
   int          n_miss = 0;
   int          c = 0;
   int          starve_left = 0;
   logic        stopped = 1'b0;
   logic [14:0] exp_d = '0;
   logic [15:0] exp_uf = '0;

   always #5 clk = ~clk;

   isl58x_seq_ctrl #(
      .CLK_DIV   (DIV),
      .H_ACTIVE  (HA),
      .H_BLANK   (HB),
      .V_ACTIVE  (VA),
      .V_BLANK   (VB),
      .PWRUP_CYC (PWR)
   ) dut (
      .clk_i           (clk),
      .sync_rst_i      (sync_rst_i),
      .enable_i        (enable_i),
      .rtz_mode_i      (rtz_mode_i),
      .pix_i           (pix_i),
      .pix_vld_i       (pix_vld_i),
      .pix_rdy_o       (pix_rdy_o),
      .isl58x_D        (isl58x_D),
      .isl58x_CLK      (isl58x_CLK),
      .isl58x_RTZ      (isl58x_RTZ),
      .isl58x_LOWP     (isl58x_LOWP),
      .isl58x_CE       (isl58x_CE),
      .frame_start_o   (frame_start_o),
      .running_o       (running_o),
      .underflow_cnt_o (underflow_cnt_o)
   );

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals();
      chk("rst_D", 16'(isl58x_D), 16'd0);
      chk("rst_CLK", 16'(isl58x_CLK), 16'd0);
      chk("rst_RTZ", 16'(isl58x_RTZ), 16'd0);
      chk("rst_LOWP", 16'(isl58x_LOWP), 16'd1);
      chk("rst_CE", 16'(isl58x_CE), 16'd0);
      chk("rst_rdy", 16'(pix_rdy_o), 16'd0);
      chk("rst_fs", 16'(frame_start_o), 16'd0);
      chk("rst_running", 16'(running_o), 16'd0);
      chk("rst_uf", underflow_cnt_o, 16'd0);
   endtask

   task automatic pwr_up();
      int  n;
      logic bad;
      enable_i   = 1'b1;
      rtz_mode_i = 1'b1;
      cyc();
      chk("wake_LOWP", 16'(isl58x_LOWP), 16'd0);
      chk("wake_CE", 16'(isl58x_CE), 16'd0);
      chk("wake_RTZ", 16'(isl58x_RTZ), 16'd1);
      rtz_mode_i = 1'b0;
      n   = 0;
      bad = 1'b0;
      while (!isl58x_CE && n < 2 * PWR) begin
         if (isl58x_CLK !== 1'b0) bad = 1'b1;
         cyc();
         n++;
      end
      chk("pwrup_len", 16'(n), 16'(PWR));
      chk("clk_idle", 16'(bad), 16'd0);
      chk("run_RTZ_held", 16'(isl58x_RTZ), 16'd1);
      chk("run_LOWP", 16'(isl58x_LOWP), 16'd0);
      c       = 0;
      exp_d   = '0;
      stopped = 1'b0;
   endtask

   // One clk cycle in RUN; mode 0 streams pixel=h, mode 1 is random.
   task automatic step_run(input int mode);
      int          pos, h, v;
      logic        tk, act, vld, stop_now, exp_clk;
      logic [14:0] px;
      tk  = (c % DIV == 0);
      pos = (c / DIV) % FT;
      h   = pos % HT;
      v   = pos / HT;
      act = tk && (h < HA) && (v < VA);
      chk("pix_rdy", 16'(pix_rdy_o), 16'(act));
      chk("frame_start", 16'(frame_start_o), 16'(tk && pos == 0));
      if (mode == 0) begin
         vld = 1'b1;
         px  = 15'(h);
      end else begin
         vld = ($urandom_range(0, 3) != 0);
         px  = 15'($urandom);
      end
      if (act && starve_left > 0) begin
         vld = 1'b0;
         starve_left--;
      end
      pix_vld_i = vld;
      pix_i     = px;
      if (tk) begin
         exp_d = (act && vld) ? px : 15'd0;
         if (act && !vld && exp_uf != 16'hFFFF) exp_uf++;
      end
      stop_now = !enable_i && (c % FC == FC - 1);
      cyc();
      c++;
      if (stop_now) begin
         stopped = 1'b1;
         chk("stop_CE", 16'(isl58x_CE), 16'd0);
         chk("stop_running", 16'(running_o), 16'd0);
         chk("stop_LOWP", 16'(isl58x_LOWP), 16'd0);
         chk("stop_D", 16'(isl58x_D), 16'd0);
         chk("stop_CLK", 16'(isl58x_CLK), 16'd0);
      end else begin
         exp_clk = (((c - 1) % DIV) >= DIV / 2);
         chk("D", 16'(isl58x_D), 16'(exp_d));
         chk("CLK", 16'(isl58x_CLK), 16'(exp_clk));
         chk("CE", 16'(isl58x_CE), 16'd1);
         chk("running", 16'(running_o), 16'd1);
         chk("uf", underflow_cnt_o, exp_uf);
      end
   endtask

   initial begin
      logic [15:0] uf0;
      int          k;
      cyc();
      cyc();
      sync_rst_i = 1'b0;
      cyc();
      chk_reset_vals();

      pwr_up();
      for (int i = 0; i < 2 * FC; i++) step_run(0);
      for (int i = 0; i < 3 * FC; i++) step_run(1);

      uf0         = exp_uf;
      starve_left = 3;
      for (int i = 0; i < FC; i++) step_run(0);
      chk("starve3", underflow_cnt_o, uf0 + 16'd3);

      for (int i = 0; i < 30; i++) step_run(1);
      enable_i = 1'b0;
      k = 0;
      while (!stopped && k < 3 * FC) begin
         step_run(1);
         k++;
      end
      chk("stop_reached", 16'(stopped), 16'd1);
      for (int i = 1; i <= DIV; i++) begin
         cyc();
         chk("stop_LOWP_seq", 16'(isl58x_LOWP), 16'(i == DIV));
      end
      chk("off_CE", 16'(isl58x_CE), 16'd0);
      chk("off_running", 16'(running_o), 16'd0);
      chk("off_CLK", 16'(isl58x_CLK), 16'd0);

      pwr_up();
      for (int i = 0; i < 101; i++) step_run(1);
      sync_rst_i = 1'b1;
      cyc();
      chk_reset_vals();
      sync_rst_i  = 1'b0;
      exp_uf      = '0;
      starve_left = 0;
      pwr_up();
      for (int i = 0; i < FC; i++) step_run(0);

      force dut.r_underflow = 16'hFFFD;
      #1;
      release dut.r_underflow;
      exp_uf      = 16'hFFFD;
      starve_left = 5;
      for (int i = 0; i < 2 * FC; i++) step_run(0);
      chk("uf_sat", underflow_cnt_o, 16'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/isl58x_seq_ctrl.md
# isl58x_seq_ctrl

Sequencer and timing controller for the ISL58315 display-DAC interface. It runs the part's power-up sequence (LOWP and CE ordering), generates the divided pixel clock, and pulls 15-bit RGB555 pixels from an upstream valid/ready stream. Each pixel is placed on the D bus inside a fixed active/blanking raster. It sits between the frame-buffer read path and the ISL58315 pins. It replaces free-running writes to D with a scheduled, glitch-free transfer.

## Interface
Parameters:
- CLK_DIV, 4: clk_i cycles per pixel; even, ≥2.
- H_ACTIVE, 1280: active pixels per line.
- H_BLANK, 160: blank pixel slots per line.
- V_ACTIVE, 800: active lines per frame.
- V_BLANK, 20: blank lines per frame.
- PWRUP_CYC, 1000: clk_i cycles from LOWP deassert to CE assert.

Ports:
- clk_i  in  1  100 MHz system clock.
- sync_rst_i  in  1  reset, synchronous, active-high.
- enable_i  in  1  level request to run the display.
- rtz_mode_i  in  1  value driven on isl58x_RTZ; sampled only in OFF.
- pix_i  in  15  {R[4:0],G[4:0],B[4:0]}.
- pix_vld_i  in  1  upstream pixel valid.
- pix_rdy_o  out  1  pixel accepted this cycle when pix_vld_i is also high.
- isl58x_D  out  15  DAC data.
- isl58x_CLK  out  1  pixel clock.
- isl58x_RTZ, isl58x_LOWP, isl58x_CE  out  1  DAC control pins.
- frame_start_o  out  1  one-cycle pulse on the first active pixel slot of a frame.
- running_o  out  1  high in RUN.
- underflow_cnt_o  out  16  saturating count of starved active slots.

## Operation
- States:
  - OFF: LOWP=1, CE=0, CLK=0, D=0.
  - WAKE: LOWP=0, CE=0, wait counter running.
  - RUN: LOWP=0, CE=1, raster running.
  - STOP: CE=0, LOWP=0, one pixel period.
- Transitions:
  - OFF→WAKE when enable_i=1. rtz_mode_i is latched into the RTZ register on this transition.
  - WAKE→RUN after PWRUP_CYC cycles.
  - WAKE→OFF immediately if enable_i drops.
  - RUN→STOP when enable_i=0 at the end of the last slot of a frame (frame boundary only; no partial frames).
  - STOP→OFF after CLK_DIV cycles.
- Raster:
  - h_cnt runs 0..H_ACTIVE+H_BLANK-1; v_cnt runs 0..V_ACTIVE+V_BLANK-1. Both advance once per pixel tick and wrap.
  - A slot is active when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - Both counters are zero on entry to RUN.
- Pixel transfer:
  - pix_rdy_o = tick & active & RUN (combinational).
  - On a tick in an active slot with pix_vld_i=1: D<=pix_i.
  - On a tick in an active slot with pix_vld_i=0: D<=0 and underflow_cnt increments, saturating at 16'hFFFF. The missed pixel is not replayed; the raster never stalls.
  - Blank slots: D<=0, no pixels consumed.
- underflow_cnt clears only on reset.

## Timing
- Reset values: D=0, CLK=0, RTZ=0, LOWP=1, CE=0, pix_rdy_o=0, frame_start_o=0, running_o=0, underflow_cnt=0, state=OFF.
- Reset mid-frame returns to OFF on the next edge. Counters clear and pixels in flight are dropped.
- Pixel tick: phase counter 0..CLK_DIV-1 runs in RUN only. Tick is phase==0.
- isl58x_CLK = 1 for phases CLK_DIV/2..CLK_DIV-1, registered. D changes only at phase 0, so D has CLK_DIV/2 cycles of setup to the CLK rising edge.
- Latency: pix_i accepted at the tick cycle appears on isl58x_D one clk_i cycle later. The corresponding CLK rise occurs CLK_DIV/2 cycles after that.
- The first tick is on the first RUN cycle; CE rises on that same edge.
- frame_start_o is coincident with pix_rdy_o for slot (0,0).
- All outputs are registered except pix_rdy_o.

## Structure
- Package isl58x_pkg holds:
  - the state enum (OFF, WAKE, RUN, STOP);
  - the pixel-width constant (15);
  - the RGB555 field offsets.
- One sub-module, isl58x_raster_cnt: it takes the tick and outputs h_cnt, v_cnt, active, last_slot and frame_first.
- Everything else (FSM, wait counter, phase divider, output registers, underflow counter) stays in the top level.

## Test plan
- Reset then enable_i=1 (PWRUP_CYC=1000): LOWP falls 1 cycle after enable. CE rises exactly 1000 cycles later. CLK idles low before CE.
- Continuous valid pixels with a small raster (H_ACTIVE=4, H_BLANK=2, V_ACTIVE=2, V_BLANK=1, pixel value = index): D sequence per line is 0,1,2,3, then 0,0. CLK period is 4 cycles. frame_start_o fires every 18 pixel ticks.
- Deassert pix_vld_i for 3 active slots: D=0 in those slots, underflow_cnt_o=3, raster position unchanged.
- enable_i=0 mid-frame: the frame completes, then CE drops, LOWP rises CLK_DIV cycles later, and running_o=0.
- sync_rst_i pulse mid-line: all outputs reach their reset values on the next edge. A re-enable restarts at slot (0,0) after a full PWRUP_CYC wait.
- Force underflow past 65535 slots: counter holds 16'hFFFF.
